// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory access stage.
//  - FSM state encoding (IDLE/REQ/WAIT/DONE) as plain 2-bit constants.
//  - Fault-cause codes reserved for future status reporting.
//  - Helper that flags byte addresses beyond the data-memory window.
package mem_stage_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  typedef enum logic [1:0] {
    CauseMisalign = 2'd0,
    CauseRange    = 2'd1,
    CauseConflict = 2'd2,
    CauseTimeout  = 2'd3
  } fault_cause_e;

  // True when any byte-address bit above the word-address field is set.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> (addr_w + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access timeout counter.
//  clk     in  rising-edge clock
//  rst     in  synchronous active-low reset
//  clear   in  force count to zero (takes priority over enable)
//  enable  in  count one per cycle
//  expire  out high while enabled and the count has reached TIMEOUT-1
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: runs execute's load/store on a handshaked, variable-latency data-memory port,
// stalling the core until the access finishes, and returns load data to execute.
//  clk, rst                   clock, synchronous active-low reset
//  ex_mem_read/ex_mem_write   request levels from execute (held while stalled)
//  ex_addr, ex_wdata          byte address and store data from execute
//  ex_rdata                   load data to execute (updated on load completion or fault)
//  stall                      freeze PC/pipeline this cycle
//  fault                      last access aborted (misaligned, out of range, conflict, timeout)
//  dmem_req/we/addr/wdata     request to data memory, zero while no request is active
//  dmem_ready                 memory accepts the request
//  dmem_rvalid/dmem_rdata     one-cycle read data return
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic [31:0]       ex_rdata,
  output logic              stall,
  output logic              fault,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ready,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              fault_q, fault_d;

  logic ex_req, bad_req, busy, timer_expire;

  assign ex_req  = ex_mem_read | ex_mem_write;
  assign bad_req = (ex_mem_read & ex_mem_write) | (ex_addr[1:0] != 2'b00)
                 | addr_out_of_range(ex_addr, ADDR_W);
  assign busy    = (state_q == StReq) | (state_q == StWait);

  // Counter runs only while on the bus and is cleared in every other state, so each
  // access starts with a fresh budget.
  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy),
    .expire (timer_expire)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle: begin
        if (ex_req) begin
          if (bad_req) begin
            fault_d = 1'b1;
            rdata_d = '0;
            state_d = StDone;
          end else begin
            addr_d  = ex_addr[ADDR_W+1:2];
            wdata_d = ex_wdata;
            we_d    = ex_mem_write;
            fault_d = 1'b0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // A completing handshake beats a timeout in the same cycle.
        if (dmem_ready && (we_q || dmem_rvalid)) begin
          if (!we_q) rdata_d = dmem_rdata;
          state_d = StDone;
        end else if (timer_expire) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else if (dmem_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (dmem_rvalid) begin
          rdata_d = dmem_rdata;
          state_d = StDone;
        end else if (timer_expire) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        // One unstalled cycle; a request still visible here belongs to the finished access.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // Gated by rst so the core and memory see no activity while reset is held.
  assign dmem_req   = rst & (state_q == StReq);
  assign stall      = rst & (busy | ((state_q == StIdle) & ex_req));
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? addr_q : '0;
  assign dmem_wdata = dmem_we ? wdata_q : '0;
  assign ex_rdata   = rdata_q;
  assign fault      = fault_q;

endmodule
